logic_unit_pipe: RTL and testbench

Parametrised, registered bitwise logic unit. It extends the plain two-input gate set to WIDTH-bit operands with opcode selection and a one-deep output register under valid/ready flow control. An internal accumulator lets a result be fed back as operand B, so gate operations can be chained without leaving the block. It sits between an operand source and any consumer that uses the standard valid/ready handshake.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_core.sv | 29 ++
 rtl/logic_unit_pipe.sv | 118 +++++++++++
 tb/tb_logic_unit_pipe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared opcode definitions for the logic_unit_pipe block.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage : logic_unit_pkg

// File: rtl/logic_unit_core.sv
// logic_unit_core: purely combinational WIDTH-bit bitwise opcode evaluator.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_y
);

  // Select the gate function for the current opcode.
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NOT:  o_y = ~i_a;
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_PASS: o_y = i_a;
      default: o_y = '0;
    endcase
  end

endmodule : logic_unit_core

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with accumulator feedback
// and a one-deep valid/ready output stage.
// Optional feature macro: LOGIC_UNIT_REDUCE_EN adds the registered
// out_par (XOR-reduce) and out_all (AND-reduce) result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc_sel,
  input  logic             in_acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic             out_par,
  output logic             out_all
`endif
);

`ifdef LOGIC_UNIT_REDUCE_EN
  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic f_all_ones(input logic [WIDTH-1:0] v);
    return &v;
  endfunction
`endif

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic             r_par;
  logic             r_all;
`endif

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  op_e              w_op;

  // The slot is free when empty or when its current result leaves this cycle.
  assign w_in_ready = ~r_valid | out_ready;
  // A beat coinciding with reset is never taken.
  assign w_accept   = in_valid & w_in_ready & ~rst;
  // Operand B is either the port or the pre-update accumulator.
  assign w_b        = in_acc_sel ? r_acc : in_b;
  assign w_op       = op_e'(in_op);

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a  (in_a),
    .i_b  (w_b),
    .i_op (w_op),
    .o_y  (w_result)
  );

  // Output stage: load on accept, drain on consume, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_zero  <= 1'b1;
`ifdef LOGIC_UNIT_REDUCE_EN
      r_par   <= 1'b0;
      r_all   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_y     <= w_result;
      r_zero  <= (w_result == '0);
`ifdef LOGIC_UNIT_REDUCE_EN
      r_par   <= f_parity(w_result);
      r_all   <= f_all_ones(w_result);
`endif
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Accumulator updates only on accepted beats that request a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && in_acc_wr) begin
      r_acc <= w_result;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_y     = r_y;
  assign out_zero  = r_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
  assign out_par   = r_par;
  assign out_all   = r_all;
`endif

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe (WIDTH=8).
module tb_logic_unit_pipe;

  localparam int         W     = 8;
  localparam logic [7:0] A_INI = 8'h5A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = 3'd0;
  logic         in_acc_sel = 1'b0;
  logic         in_acc_wr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         out_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic         out_par;
  logic         out_all;
`endif

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(A_INI)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_acc_sel(in_acc_sel), .in_acc_wr(in_acc_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero)
`ifdef LOGIC_UNIT_REDUCE_EN
    , .out_par(out_par), .out_all(out_all)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic         p;
    logic         a;
  } exp_t;

  exp_t       sb_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_acc   = A_INI;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // One clock: drive at negedge, check head of scoreboard, model the edge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic sel, input logic wr, input logic rdy);
    logic   acc_ok;
    logic [7:0] r;
    exp_t   e;
    @(negedge clk);
    in_valid = v; in_op = op; in_a = a; in_b = b;
    in_acc_sel = sel; in_acc_wr = wr; out_ready = rdy;
    #1;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, (~m_valid | rdy)});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid && sb_q.size() > 0) begin
      e = sb_q[0];
      check_eq("out_y", {24'd0, out_y}, {24'd0, e.y});
      check_eq("out_zero", {31'd0, out_zero}, {31'd0, e.z});
`ifdef LOGIC_UNIT_REDUCE_EN
      check_eq("out_par", {31'd0, out_par}, {31'd0, e.p});
      check_eq("out_all", {31'd0, out_all}, {31'd0, e.a});
`endif
      if (rdy) void'(sb_q.pop_front());
    end
    acc_ok = v & (~m_valid | rdy);
    if (acc_ok) begin
      r = ref_op(op, a, sel ? m_acc : b);
      e.y = r; e.z = (r == 8'h00); e.p = ^r; e.a = &r;
      sb_q.push_back(e);
      if (wr) m_acc = r;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Reset for two edges while a beat is offered; the beat must be dropped.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_op = 3'd7; in_a = 8'hC3; in_acc_wr = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_y", {24'd0, out_y}, 32'd0);
    check_eq("rst_out_zero", {31'd0, out_zero}, 32'd1);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef LOGIC_UNIT_REDUCE_EN
    check_eq("rst_out_par", {31'd0, out_par}, 32'd0);
    check_eq("rst_out_all", {31'd0, out_all}, 32'd0);
`endif
    sb_q.delete();
    m_valid = 1'b0;
    m_acc   = A_INI;
  endtask

  initial begin
    do_reset();
    // Accumulator reset value visible through OR with a=0.
    cycle(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    // Basic gates.
    cycle(1'b1, 3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd4, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    // Chaining through the accumulator, including read-before-write.
    cycle(1'b1, 3'd7, 8'h55, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 3'd5, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 3'd1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b1);
    // Backpressure: result held three cycles while a beat waits.
    cycle(1'b1, 3'd1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1);
    // Streaming all opcodes back to back.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 3'(i), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    // Reduction corner values.
    cycle(1'b1, 3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd7, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 3'd7, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // Reset with a pending result and a modified accumulator.
    do_reset();
    cycle(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_logic_unit_pipe
